// File: rtl/icache_core.sv
// Direct-mapped, read-only instruction cache with 64-byte lines and register-based storage.
// A miss issues one line-aligned refill, then returns the requested word one cycle after the fill.
module icache_core #(
   parameter int INDEX_WIDTH = 6,
   localparam int TAG_WIDTH = 26 - INDEX_WIDTH
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         cpu_req,
   input  logic [31:0]  cpu_addr,
   output logic [31:0]  cpu_rdata,
   output logic         cpu_rvalid,
   output logic         busy,
   input  logic         flush,
   output logic         miss,
   output logic [31:0]  miss_addr,
   input  logic         miss_accept,
   input  logic         fill_wen,
   input  logic [511:0] fill_data,
   output logic [31:0]  hit_cnt,
   output logic [31:0]  miss_cnt
);

   localparam int LINES = 1 << INDEX_WIDTH;

   typedef enum logic [1:0] {IDLE, MISS, RESP} state_t;
   state_t state_q, state_d;

   logic [LINES-1:0]     valid_q;
   logic [TAG_WIDTH-1:0] tag_q  [LINES];
   logic [511:0]         data_q [LINES];
   logic [31:2]          req_addr_q;
   logic [31:0]          resp_word_q;
   logic                 flush_pend_q;

   logic [INDEX_WIDTH-1:0] lk_idx, rq_idx;
   logic [TAG_WIDTH-1:0]   lk_tag, rq_tag;
   logic [3:0]             lk_off, rq_off;
   logic                   flush_now, lookup_hit, start_miss, fill_now;
   logic                   unused_ok;

   assign lk_idx = cpu_addr[6 +: INDEX_WIDTH];
   assign lk_tag = cpu_addr[31 -: TAG_WIDTH];
   assign lk_off = cpu_addr[5:2];
   assign rq_idx = req_addr_q[6 +: INDEX_WIDTH];
   assign rq_tag = req_addr_q[31 -: TAG_WIDTH];
   assign rq_off = req_addr_q[5:2];

   // A flush (live or deferred) wipes the array on this edge, so the lookup cannot hit.
   assign flush_now  = (state_q == IDLE) && (flush || flush_pend_q);
   assign lookup_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag) && !flush_now;
   assign start_miss = (state_q == IDLE) && cpu_req && !lookup_hit;
   assign fill_now   = (state_q == MISS) && fill_wen;
   assign busy       = (state_q != IDLE);
   assign unused_ok  = ^{cpu_addr[1:0], miss_accept};

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (cpu_req && !lookup_hit) state_d = MISS;
         MISS:    if (fill_wen) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q      <= '0;
         flush_pend_q <= 1'b0;
         cpu_rvalid   <= 1'b0;
         cpu_rdata    <= '0;
         miss         <= 1'b0;
         miss_addr    <= '0;
         hit_cnt      <= '0;
         miss_cnt     <= '0;
      end else begin
         cpu_rvalid <= 1'b0;
         if (flush_now) begin
            valid_q <= '0;
         end else if (fill_now) begin
            valid_q[rq_idx] <= 1'b1;
         end
         if (state_q == IDLE) begin
            flush_pend_q <= 1'b0;
         end else if (flush) begin
            flush_pend_q <= 1'b1;
         end
         if ((state_q == IDLE) && cpu_req && lookup_hit) begin
            cpu_rvalid <= 1'b1;
            cpu_rdata  <= data_q[lk_idx][{lk_off, 5'b0} +: 32];
            hit_cnt    <= hit_cnt + 32'd1;
         end
         if (start_miss) begin
            miss      <= 1'b1;
            miss_addr <= {cpu_addr[31:6], 6'b0};
            miss_cnt  <= miss_cnt + 32'd1;
         end
         // miss drops on the fill edge so the refill side sees it low when it goes idle.
         if (fill_now) begin
            miss <= 1'b0;
         end
         if (state_q == RESP) begin
            cpu_rvalid <= 1'b1;
            cpu_rdata  <= resp_word_q;
         end
      end
   end

   // Tag/data storage and request latch carry no reset; valid_q and state_q qualify them.
   always_ff @(posedge clk) begin
      if (start_miss) begin
         req_addr_q <= cpu_addr[31:2];
      end
      if (fill_now) begin
         tag_q[rq_idx]  <= rq_tag;
         data_q[rq_idx] <= fill_data;
         resp_word_q    <= fill_data[{rq_off, 5'b0} +: 32];
      end
   end

endmodule

// File: tb/tb_icache_core.sv
// Self-checking bench for icache_core: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a line-level cache model.
module tb_icache_core;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         cpu_req = 1'b0;
   logic [31:0]  cpu_addr = '0;
   logic [31:0]  cpu_rdata;
   logic         cpu_rvalid;
   logic         busy;
   logic         flush = 1'b0;
   logic         miss;
   logic [31:0]  miss_addr;
   logic         miss_accept = 1'b1;
   logic         fill_wen = 1'b0;
   logic [511:0] fill_data = '0;
   logic [31:0]  hit_cnt;
   logic [31:0]  miss_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_hits = 0;
   int exp_misses = 0;

   // Model: index -> line address currently held (absent means invalid).
   logic [31:0] cache_line [int];

   typedef struct {
      logic [31:0] addr;
      bit          hit;
      logic [31:0] word;
   } vec_t;
   vec_t vecs [7];

   icache_core #(.INDEX_WIDTH(6)) dut (
      .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
      .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .busy(busy), .flush(flush),
      .miss(miss), .miss_addr(miss_addr), .miss_accept(miss_accept),
      .fill_wen(fill_wen), .fill_data(fill_data), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_word(input logic [31:0] la, input int k);
      return 32'hA000_0000 + 32'd7 * (la ^ 32'h0000_1000) + 32'(k);
   endfunction

   function automatic logic [511:0] mk_line(input logic [31:0] la);
      logic [511:0] l;
      for (int k = 0; k < 16; k++) l[32*k +: 32] = ref_word(la, k);
      return l;
   endfunction

   function automatic int idx_of(input logic [31:0] a);
      return int'(a[11:6]);
   endfunction

   // flush_at: -2 none, -1 together with the request, >=0 during that wait cycle of the miss.
   task automatic do_access(input logic [31:0] addr, input bit exp_hit, input logic [31:0] exp_word,
                            input int delay, input int flush_at, input bit noise);
      logic [31:0] la;
      la = {addr[31:6], 6'b0};
      if (flush_at == -1) cache_line.delete();
      cpu_req = 1'b1;
      cpu_addr = addr;
      flush = (flush_at == -1);
      step();
      cpu_req = 1'b0;
      flush = 1'b0;
      if (exp_hit) begin
         exp_hits++;
         check("hit_rvalid", {31'b0, cpu_rvalid}, 32'd1);
         check("hit_rdata", cpu_rdata, exp_word);
         check("hit_busy", {31'b0, busy}, 32'd0);
         check("hit_miss", {31'b0, miss}, 32'd0);
         check("hit_cnt", hit_cnt, 32'(exp_hits));
      end else begin
         exp_misses++;
         check("miss_req", {31'b0, miss}, 32'd1);
         check("miss_addr", miss_addr, la);
         check("miss_busy", {31'b0, busy}, 32'd1);
         check("miss_rvalid", {31'b0, cpu_rvalid}, 32'd0);
         check("miss_cnt", miss_cnt, 32'(exp_misses));
         for (int c = 0; c < delay; c++) begin
            if (noise) begin
               cpu_req = 1'($urandom_range(0, 1));
               cpu_addr = $urandom;
            end
            flush = (flush_at == c);
            step();
            check("miss_hold", {31'b0, miss}, 32'd1);
         end
         flush = 1'b0;
         fill_wen = 1'b1;
         fill_data = mk_line(la);
         step();
         fill_wen = 1'b0;
         fill_data = {16{$urandom}};
         check("fill_miss_drop", {31'b0, miss}, 32'd0);
         check("fill_rvalid", {31'b0, cpu_rvalid}, 32'd0);
         check("fill_busy", {31'b0, busy}, 32'd1);
         step();
         cpu_req = 1'b0;
         check("resp_rvalid", {31'b0, cpu_rvalid}, 32'd1);
         check("resp_rdata", cpu_rdata, exp_word);
         check("resp_busy", {31'b0, busy}, 32'd0);
         check("resp_hit_cnt", hit_cnt, 32'(exp_hits));
         check("resp_miss_cnt", miss_cnt, 32'(exp_misses));
         step();
         check("resp_pulse_end", {31'b0, cpu_rvalid}, 32'd0);
         cache_line[idx_of(addr)] = la;
         if (flush_at >= 0) cache_line.delete();
      end
   endtask

   task automatic model_access(input logic [31:0] addr, input int delay, input int flush_at, input bit noise);
      logic [31:0] la;
      bit h;
      la = {addr[31:6], 6'b0};
      if (flush_at == -1) cache_line.delete();
      h = cache_line.exists(idx_of(addr)) && (cache_line[idx_of(addr)] == la);
      do_access(addr, h, ref_word(la, int'(addr[5:2])), delay, flush_at, noise);
   endtask

   initial begin
      vecs[0] = '{32'h0000_1004, 1'b0, 32'hA000_0001};
      vecs[1] = '{32'h0000_1000, 1'b1, 32'hA000_0000};
      vecs[2] = '{32'h0000_103C, 1'b1, 32'hA000_000F};
      vecs[3] = '{32'h0000_1020, 1'b1, 32'hA000_0008};
      vecs[4] = '{32'h0000_1000, 1'b1, 32'hA000_0000};
      vecs[5] = '{32'h0000_2000, 1'b0, 32'hA001_5000};
      vecs[6] = '{32'h0000_1000, 1'b0, 32'hA000_0000};

      // Reset state
      repeat (3) step();
      check("rst_rvalid", {31'b0, cpu_rvalid}, 32'd0);
      check("rst_rdata", cpu_rdata, 32'd0);
      check("rst_miss", {31'b0, miss}, 32'd0);
      check("rst_miss_addr", miss_addr, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_hit_cnt", hit_cnt, 32'd0);
      check("rst_miss_cnt", miss_cnt, 32'd0);
      rst_n = 1'b1;
      step();

      // Directed vectors: first miss, consecutive hits, index conflict
      for (int i = 0; i < 7; i++) do_access(vecs[i].addr, vecs[i].hit, vecs[i].word, 2, -2, 1'b0);
      check("tbl_hit_total", hit_cnt, 32'd4);
      check("tbl_miss_total", miss_cnt, 32'd3);

      // Deferred flush: flush during MISS, the line is still returned, then invalid
      model_access(32'h0000_4440, 4, 1, 1'b0);
      check("defer_flush_model", {31'b0, cache_line.exists(idx_of(32'h0000_4440))}, 32'd0);
      model_access(32'h0000_4448, 2, -2, 1'b0);
      model_access(32'h0000_4444, 0, -2, 1'b0);
      // Flush in IDLE with a request that would have hit: counts as a miss
      model_access(32'h0000_4444, 1, -1, 1'b0);

      // Reset during MISS abandons the refill; a late fill is ignored
      cpu_req = 1'b1;
      cpu_addr = 32'h0000_5080;
      step();
      cpu_req = 1'b0;
      check("rm_miss_before", {31'b0, miss}, 32'd1);
      #3 rst_n = 1'b0;
      #1;
      check("rm_miss", {31'b0, miss}, 32'd0);
      check("rm_busy", {31'b0, busy}, 32'd0);
      check("rm_hit_cnt", hit_cnt, 32'd0);
      check("rm_miss_cnt", miss_cnt, 32'd0);
      step();
      step();
      rst_n = 1'b1;
      cache_line.delete();
      exp_hits = 0;
      exp_misses = 0;
      step();
      fill_wen = 1'b1;
      fill_data = mk_line(32'h0000_5080);
      step();
      fill_wen = 1'b0;
      check("late_fill_busy", {31'b0, busy}, 32'd0);
      check("late_fill_rvalid", {31'b0, cpu_rvalid}, 32'd0);
      model_access(32'h0000_5084, 1, -2, 1'b0);

      // Long refill with miss_accept held high; exactly one line written
      model_access(32'h0000_6100, 40, -2, 1'b0);
      model_access(32'h0000_6134, 0, -2, 1'b0);
      model_access(32'h0000_6140, 1, -2, 1'b0);

      // Randomized traffic against the model, with requests injected while busy
      for (int n = 0; n < 200; n++) begin
         logic [31:0] a;
         int d, fa, r;
         a = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 3)) << 6)
             | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
         d = $urandom_range(0, 5);
         r = $urandom_range(0, 9);
         fa = -2;
         if (r == 0) fa = -1;
         else if (r == 1 && d > 0) fa = $urandom_range(0, d - 1);
         model_access(a, d, fa, 1'b1);
      end
      check("rand_hit_total", hit_cnt, 32'(exp_hits));
      check("rand_miss_total", miss_cnt, 32'(exp_misses));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
